// File: rtl/drv_ps2_scan.sv
// ---------------------------------------------------------------------------
// drv_ps2_scan
//
// Decodes PS/2 scan-code set 2 byte sequences (E0 extended and F0 break
// prefixes) from the PS/2 byte receiver into key events. Each event is
// {ext, brk, code}. Events are queued in a small show-ahead FIFO that the
// keyboard consumer drains with a valid/ready handshake.
//
// Optional build macro: DRV_PS2_SCAN_PAUSE_EN
//   When defined, the 8-byte Pause sequence (E1 plus 7 bytes) is collapsed
//   into one event {ext=1, brk=0, code=E1}. When undefined, E1 is an
//   ordinary code byte.
//
// Parameters
//   p_depth    event FIFO depth in entries (power of two, >= 2)
//   p_timeout  idle cycles after a prefix byte before the prefix is dropped
//
// Ports
//   i_clk   system clock
//   i_rst   asynchronous active-high reset
//   i_dat   received byte from the PS/2 receiver
//   i_vld   one-cycle strobe: i_dat holds a new byte
//   i_err   receiver frame error, sampled with i_vld
//   o_code  key code of the head event
//   o_ext   head event is extended (E0-prefixed)
//   o_brk   head event is a break (key release)
//   o_vld   FIFO non-empty; head event presented
//   i_rdy   consumer accepts the head event when o_vld & i_rdy
//   o_ovf   one-cycle pulse: event dropped because the FIFO was full
//   o_ovr   one-cycle pulse: keyboard sent overrun byte 00 or FF
// ---------------------------------------------------------------------------
module drv_ps2_scan #(
    parameter int          p_depth   = 4,
    parameter logic [15:0] p_timeout = 16'd50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_dat,
    input  logic       i_vld,
    input  logic       i_err,
    output logic [7:0] o_code,
    output logic       o_ext,
    output logic       o_brk,
    output logic       o_vld,
    input  logic       i_rdy,
    output logic       o_ovf,
    output logic       o_ovr
);

    localparam int c_aw = $clog2(p_depth);

`ifdef DRV_PS2_SCAN_PAUSE_EN
    typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;
`endif

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        push;
    logic [9:0]  push_word;
    logic        ovr_nxt;
    logic        timeout;

`ifdef DRV_PS2_SCAN_PAUSE_EN
    logic [2:0]  pause_cnt, pause_cnt_nxt;
`endif

    // Prefix is abandoned only while idle on the bus; a byte arriving on the
    // expiry cycle is still decoded in the prefix state.
    assign timeout = (state != S_IDLE) && (cnt == p_timeout - 16'd1);

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_word = {2'b00, i_dat};
        ovr_nxt   = 1'b0;
`ifdef DRV_PS2_SCAN_PAUSE_EN
        pause_cnt_nxt = pause_cnt;
`endif
        if (i_vld && i_err) begin
            state_nxt = S_IDLE;
        end else if (i_vld) begin
            case (state)
                S_IDLE: begin
                    case (i_dat)
                        8'hE0: state_nxt = S_E0;
                        8'hF0: state_nxt = S_F0;
                        8'h00, 8'hFF: ovr_nxt = 1'b1;
                        // Keyboard status/ack bytes carry no key event.
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'hFD: ;
`ifdef DRV_PS2_SCAN_PAUSE_EN
                        8'hE1: begin
                            state_nxt     = S_PAUSE;
                            pause_cnt_nxt = 3'd0;
                        end
`endif
                        default: push = 1'b1;
                    endcase
                end
                S_E0: begin
                    if (i_dat == 8'hF0) begin
                        state_nxt = S_E0F0;
                    end else if (i_dat != 8'hE0) begin
                        push      = 1'b1;
                        push_word = {2'b10, i_dat};
                        state_nxt = S_IDLE;
                    end
                end
                S_F0: begin
                    state_nxt = S_IDLE;
                    if (i_dat != 8'hE0 && i_dat != 8'hF0) begin
                        push      = 1'b1;
                        push_word = {2'b01, i_dat};
                    end
                end
                S_E0F0: begin
                    state_nxt = S_IDLE;
                    if (i_dat != 8'hE0 && i_dat != 8'hF0) begin
                        push      = 1'b1;
                        push_word = {2'b11, i_dat};
                    end
                end
`ifdef DRV_PS2_SCAN_PAUSE_EN
                S_PAUSE: begin
                    // Byte values are ignored; only the count matters.
                    if (pause_cnt == 3'd6) begin
                        push      = 1'b1;
                        push_word = {2'b10, 8'hE1};
                        state_nxt = S_IDLE;
                    end else begin
                        pause_cnt_nxt = pause_cnt + 3'd1;
                    end
                end
`endif
                default: state_nxt = S_IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = S_IDLE;
        end

        if (i_vld || state == S_IDLE || timeout) cnt_nxt = 16'd0;
        else                                     cnt_nxt = cnt + 16'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
            cnt   <= 16'd0;
            o_ovr <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            o_ovr <= ovr_nxt;
        end
    end

`ifdef DRV_PS2_SCAN_PAUSE_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) pause_cnt <= 3'd0;
        else       pause_cnt <= pause_cnt_nxt;
    end
`endif

    // ---------------------------------------------------------------- FIFO
    logic [9:0]    mem [p_depth];
    logic [c_aw:0] wr_ptr, rd_ptr;
    logic          empty, full, pop, wr_en;
    logic [9:0]    head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[c_aw] != rd_ptr[c_aw]) &&
                   (wr_ptr[c_aw-1:0] == rd_ptr[c_aw-1:0]);
    assign pop   = !empty && i_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_ovf  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            o_ovf <= push && full && !pop;
        end
    end

    // NOTE: storage has no reset; only the pointers define what is valid,
    // which keeps the array mappable to plain registers or RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr[c_aw-1:0]] <= push_word;
    end

    // Head fields are forced to zero while empty so reset shows all-zero
    // outputs and the bus stays stable when nothing is presented.
    assign head   = mem[rd_ptr[c_aw-1:0]];
    assign o_vld  = !empty;
    assign o_code = empty ? 8'h00 : head[7:0];
    assign o_brk  = empty ? 1'b0  : head[8];
    assign o_ext  = empty ? 1'b0  : head[9];

endmodule

// File: tb/tb_drv_ps2_scan.sv
// ---------------------------------------------------------------------------
// tb_drv_ps2_scan
//
// Directed bench for drv_ps2_scan with default parameters (p_depth=4,
// p_timeout=50000). Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, away from the active edge.
// The Pause scenario is compiled in when DRV_PS2_SCAN_PAUSE_EN is defined.
// ---------------------------------------------------------------------------
module tb_drv_ps2_scan;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_dat = 8'h00;
    logic       i_vld = 1'b0;
    logic       i_err = 1'b0;
    logic       i_rdy = 1'b0;
    logic [7:0] o_code;
    logic       o_ext, o_brk, o_vld, o_ovf, o_ovr;

    int checks = 0;
    int errors = 0;

    drv_ps2_scan dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_dat (i_dat),
        .i_vld (i_vld),
        .i_err (i_err),
        .o_code(o_code),
        .o_ext (o_ext),
        .o_brk (o_brk),
        .o_vld (o_vld),
        .i_rdy (i_rdy),
        .o_ovf (o_ovf),
        .o_ovr (o_ovr)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One byte strobe; returns 1 unit after the edge that consumed it.
    task automatic send(input logic [7:0] d, input logic e);
        i_dat = d;
        i_vld = 1'b1;
        i_err = e;
        tick();
        i_vld = 1'b0;
        i_err = 1'b0;
    endtask

    // Capture the presented head event, then accept it for one cycle.
    task automatic pop_event(output logic v, output logic [7:0] c,
                             output logic x, output logic b);
        v = o_vld;
        c = o_code;
        x = o_ext;
        b = o_brk;
        i_rdy = 1'b1;
        tick();
        i_rdy = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({o_vld, o_code, o_ext, o_brk, o_ovf, o_ovr} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b code=%h ext=%b brk=%b ovf=%b ovr=%b, want all 0",
                     o_vld, o_code, o_ext, o_brk, o_ovf, o_ovr);
        end
        tick();
        i_rst = 1'b0;
        tick();
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_vld: got %b want 0", o_vld);
        end
    endtask

    task automatic test_make();
        i_rdy = 1'b1;
        send(8'h1C, 1'b0);
        checks++;
        if ({o_vld, o_code, o_ext, o_brk} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL make_1c: got vld=%b code=%h ext=%b brk=%b want 1 1c 0 0",
                     o_vld, o_code, o_ext, o_brk);
        end
        tick();
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL make_1c_popped: got vld=%b want 0", o_vld);
        end
        i_rdy = 1'b0;
    endtask

    task automatic test_prefix();
        logic v, x, b;
        logic [7:0] c;
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL e0f0_no_event: got vld=%b want 0", o_vld);
        end
        send(8'h75, 1'b0);
        pop_event(v, c, x, b);
        checks++;
        if ({v, c, x, b} !== {1'b1, 8'h75, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL e0f075: got vld=%b code=%h ext=%b brk=%b want 1 75 1 1", v, c, x, b);
        end
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL e0f075_single: got vld=%b want 0", o_vld);
        end
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        pop_event(v, c, x, b);
        checks++;
        if ({v, c, x, b} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL f01c: got vld=%b code=%h ext=%b brk=%b want 1 1c 0 1", v, c, x, b);
        end
        // Repeated E0 keeps the extended prefix.
        send(8'hE0, 1'b0);
        send(8'hE0, 1'b0);
        send(8'h74, 1'b0);
        pop_event(v, c, x, b);
        checks++;
        if ({v, c, x, b} !== {1'b1, 8'h74, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL e0e074: got vld=%b code=%h ext=%b brk=%b want 1 74 1 0", v, c, x, b);
        end
        // F0 followed by E0 aborts; next byte is a plain make.
        send(8'hF0, 1'b0);
        send(8'hE0, 1'b0);
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL f0e0_no_event: got vld=%b want 0", o_vld);
        end
        send(8'h2A, 1'b0);
        pop_event(v, c, x, b);
        checks++;
        if ({v, c, x, b} !== {1'b1, 8'h2A, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL f0e0_then_2a: got vld=%b code=%h ext=%b brk=%b want 1 2a 0 0", v, c, x, b);
        end
        // Status bytes are swallowed.
        send(8'hAA, 1'b0);
        send(8'hFA, 1'b0);
        send(8'hFE, 1'b0);
        checks++;
        if (o_vld !== 1'b0 || o_ovr !== 1'b0) begin
            errors++;
            $display("FAIL status_dropped: got vld=%b ovr=%b want 0 0", o_vld, o_ovr);
        end
    endtask

    task automatic test_timeout();
        logic v, x, b;
        logic [7:0] c;
        send(8'hE0, 1'b0);
        repeat (100) tick();
        send(8'h1C, 1'b0);
        pop_event(v, c, x, b);
        checks++;
        if ({v, c, x, b} !== {1'b1, 8'h1C, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL short_gap_keeps_e0: got vld=%b code=%h ext=%b brk=%b want 1 1c 1 0", v, c, x, b);
        end
        send(8'hE0, 1'b0);
        repeat (60000) tick();
        send(8'h1C, 1'b0);
        pop_event(v, c, x, b);
        checks++;
        if ({v, c, x, b} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_drops_e0: got vld=%b code=%h ext=%b brk=%b want 1 1c 0 0", v, c, x, b);
        end
    endtask

    task automatic test_overflow();
        logic v, x, b;
        logic [7:0] c;
        logic [7:0] codes [5];
        codes = '{8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
        for (int i = 0; i < 5; i++) begin
            send(codes[i], 1'b0);
            checks++;
            if (o_ovf !== (i == 4)) begin
                errors++;
                $display("FAIL ovf_push%0d: got ovf=%b want %b", i, o_ovf, (i == 4));
            end
        end
        tick();
        checks++;
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_single_pulse: got %b want 0", o_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            pop_event(v, c, x, b);
            checks++;
            if ({v, c, x, b} !== {1'b1, codes[i], 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL ovf_drain%0d: got vld=%b code=%h want 1 %h", i, v, c, codes[i]);
            end
        end
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drained_empty: got vld=%b want 0", o_vld);
        end
        // Full FIFO with simultaneous push and pop: both succeed.
        send(8'h1A, 1'b0);
        send(8'h1B, 1'b0);
        send(8'h1D, 1'b0);
        send(8'h1E, 1'b0);
        i_rdy = 1'b1;
        send(8'h21, 1'b0);
        i_rdy = 1'b0;
        checks++;
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop_ovf: got %b want 0", o_ovf);
        end
        codes = '{8'h1B, 8'h1D, 8'h1E, 8'h21, 8'h00};
        for (int i = 0; i < 4; i++) begin
            pop_event(v, c, x, b);
            checks++;
            if ({v, c} !== {1'b1, codes[i]}) begin
                errors++;
                $display("FAIL full_push_pop_drain%0d: got vld=%b code=%h want 1 %h", i, v, c, codes[i]);
            end
        end
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop_empty: got vld=%b want 0", o_vld);
        end
    endtask

    task automatic test_err_ovr();
        logic v, x, b;
        logic [7:0] c;
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b1);
        send(8'h1C, 1'b0);
        pop_event(v, c, x, b);
        checks++;
        if ({v, c, x, b} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL err_resets_prefix: got vld=%b code=%h ext=%b brk=%b want 1 1c 0 0", v, c, x, b);
        end
        send(8'h33, 1'b1);
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL err_byte_dropped: got vld=%b want 0", o_vld);
        end
        send(8'hFF, 1'b0);
        checks++;
        if (o_ovr !== 1'b1 || o_vld !== 1'b0) begin
            errors++;
            $display("FAIL ovr_ff: got ovr=%b vld=%b want 1 0", o_ovr, o_vld);
        end
        tick();
        checks++;
        if (o_ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_pulse_end: got %b want 0", o_ovr);
        end
        send(8'h00, 1'b0);
        checks++;
        if (o_ovr !== 1'b1 || o_vld !== 1'b0) begin
            errors++;
            $display("FAIL ovr_00: got ovr=%b vld=%b want 1 0", o_ovr, o_vld);
        end
        tick();
    endtask

    task automatic test_e1();
        logic v, x, b;
        logic [7:0] c;
`ifdef DRV_PS2_SCAN_PAUSE_EN
        logic [7:0] seq [7];
        seq = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        send(8'hE1, 1'b0);
        for (int i = 0; i < 6; i++) send(seq[i], 1'b0);
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL pause_swallow: got vld=%b want 0", o_vld);
        end
        send(seq[6], 1'b0);
        pop_event(v, c, x, b);
        checks++;
        if ({v, c, x, b} !== {1'b1, 8'hE1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL pause_event: got vld=%b code=%h ext=%b brk=%b want 1 e1 1 0", v, c, x, b);
        end
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL pause_single: got vld=%b want 0", o_vld);
        end
        // Reset in the middle of a Pause sequence with an event queued.
        send(8'h1C, 1'b0);
        send(8'hE1, 1'b0);
        send(8'h14, 1'b0);
        i_rst = 1'b1;
        #2;
        checks++;
        if ({o_vld, o_code, o_ext, o_brk, o_ovf, o_ovr} !== 13'd0) begin
            errors++;
            $display("FAIL pause_reset_outputs: got vld=%b code=%h ext=%b brk=%b want all 0",
                     o_vld, o_code, o_ext, o_brk);
        end
        i_rst = 1'b0;
        tick();
        send(8'h2B, 1'b0);
        pop_event(v, c, x, b);
        checks++;
        if ({v, c, x, b} !== {1'b1, 8'h2B, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL pause_reset_idle: got vld=%b code=%h ext=%b brk=%b want 1 2b 0 0", v, c, x, b);
        end
`else
        send(8'hE1, 1'b0);
        pop_event(v, c, x, b);
        checks++;
        if ({v, c, x, b} !== {1'b1, 8'hE1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL e1_plain: got vld=%b code=%h ext=%b brk=%b want 1 e1 0 0", v, c, x, b);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_make();
        test_prefix();
        test_timeout();
        test_overflow();
        test_err_ovr();
        test_e1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
